// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N-to-1 select mux.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_t;

  // Select width never collapses to zero bits, even for degenerate NUM_IN.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Combinational NUM_IN-to-1 word select; out-of-range selects fall back to the
// last input and raise sel_err.
module mux_n_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    sel_err
);

  always_comb begin
    data    = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
    sel_err = (int'(sel) >= NUM_IN);
    for (int k = 0; k < NUM_IN - 1; k++) begin
      if (int'(sel) == k) data = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_pipe_sel.sv
// Registered N-to-1 select with valid/ready handshake, a 2-entry skid buffer
// (OUT + SKID) and a synchronous flush that drops every held word.
module mux_pipe_sel
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] mux_data_p0;
  logic             mux_err_p0;

  mux_n_to_1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data (in_data),
    .sel     (in_sel),
    .data    (mux_data_p0),
    .sel_err (mux_err_p0)
  );

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             acc, emit;
  logic             load_out, load_skid, skid_to_out;
  logic [WIDTH-1:0] out_data_p1, skid_data_p1;
  logic             out_err_p1, skid_err_p1;
  logic             vld_p1;

  assign vld_p1 = (state_q != ST_EMPTY);
  assign acc    = in_valid & in_ready_q;
  assign emit   = vld_p1 & out_ready;

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d  = ST_ONE;
          load_out = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && emit) begin
          load_out = 1'b1;
        end else if (acc) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (emit) begin
          state_d     = ST_ONE;
          skid_to_out = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush only clears occupancy; data registers keep their last contents.
    if (flush) begin
      state_d     = ST_EMPTY;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Stage p0 -> p1: selected word lands in OUT, or in SKID while OUT is stalled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_data_p1  <= '0;
      out_err_p1   <= 1'b0;
      skid_data_p1 <= '0;
      skid_err_p1  <= 1'b0;
    end else begin
      if (load_out) begin
        out_data_p1 <= mux_data_p0;
        out_err_p1  <= mux_err_p0;
      end else if (skid_to_out) begin
        out_data_p1 <= skid_data_p1;
        out_err_p1  <= skid_err_p1;
      end
      if (load_skid) begin
        skid_data_p1 <= mux_data_p0;
        skid_err_p1  <= mux_err_p0;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = vld_p1;
  assign out_data    = out_data_p1;
  assign out_sel_err = out_err_p1;

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Bench for mux_pipe_sel: table vectors, directed stall/flush/reset sequences
// and a random soak, all checked against a queue-based reference model.
module tb_mux_pipe_sel;

  logic Clk, Reset_n;

  // Instance a: WIDTH=32 NUM_IN=4; instance b: NUM_IN=3 sharing a's stimulus.
  logic [31:0]  a_words [4];
  logic [1:0]   a_sel;
  logic         a_in_valid, a_out_ready, a_flush;
  logic [127:0] a_in_data;
  logic [95:0]  b_in_data;
  logic         a_in_ready, a_out_valid, a_err;
  logic [31:0]  a_out_data;
  logic         b_in_ready, b_out_valid, b_err;
  logic [31:0]  b_out_data;

  // Instance c: WIDTH=8 NUM_IN=5 for the soak.
  logic [7:0]   c_words [5];
  logic [2:0]   c_sel;
  logic         c_in_valid, c_out_ready, c_flush;
  logic [39:0]  c_in_data;
  logic         c_in_ready, c_out_valid, c_err;
  logic [7:0]   c_out_data;

  assign a_in_data = {a_words[3], a_words[2], a_words[1], a_words[0]};
  assign b_in_data = {a_words[2], a_words[1], a_words[0]};
  assign c_in_data = {c_words[4], c_words[3], c_words[2], c_words[1], c_words[0]};

  mux_pipe_sel #(.WIDTH(32), .NUM_IN(4)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .in_data(a_in_data), .in_sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
    .out_data(a_out_data), .out_sel_err(a_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  mux_pipe_sel #(.WIDTH(32), .NUM_IN(3)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .in_data(b_in_data), .in_sel(a_sel),
    .in_valid(a_in_valid), .in_ready(b_in_ready), .flush(a_flush),
    .out_data(b_out_data), .out_sel_err(b_err), .out_valid(b_out_valid),
    .out_ready(a_out_ready)
  );

  mux_pipe_sel #(.WIDTH(8), .NUM_IN(5)) u_c (
    .Clk(Clk), .Reset_n(Reset_n), .in_data(c_in_data), .in_sel(c_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .flush(c_flush),
    .out_data(c_out_data), .out_sel_err(c_err), .out_valid(c_out_valid),
    .out_ready(c_out_ready)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two words; ready means "fewer than two held".
  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic        eb;
  } ab_t;
  typedef struct {
    logic [7:0] d;
    logic       e;
  } c_t;

  ab_t qa[$];
  c_t  qc[$];
  int  acc_a = 0;
  bit  chk_a = 0, chk_c = 0;
  bit  a_take, c_take;
  ab_t ea;
  c_t  ec;
  int  cidx;

  always @(posedge Clk) begin
    if (Reset_n) begin
      if (a_flush) qa.delete();
      else begin
        a_take = a_in_valid && (qa.size() < 2);
        if (a_out_ready && qa.size() > 0) void'(qa.pop_front());
        if (a_take) begin
          ea.da = a_words[a_sel];
          ea.db = (a_sel < 2'd3) ? a_words[a_sel] : a_words[2];
          ea.eb = (a_sel == 2'd3);
          qa.push_back(ea);
          acc_a++;
        end
      end
      if (c_flush) qc.delete();
      else begin
        c_take = c_in_valid && (qc.size() < 2);
        if (c_out_ready && qc.size() > 0) void'(qc.pop_front());
        if (c_take) begin
          cidx = (c_sel < 3'd5) ? int'(c_sel) : 4;
          ec.d = c_words[cidx];
          ec.e = (c_sel >= 3'd5);
          qc.push_back(ec);
        end
      end
    end
  end

  always @(negedge Reset_n) begin
    qa.delete();
    qc.delete();
  end

  logic [7:0] c_prev_data;
  bit         c_prev_hold = 0;

  always @(negedge Clk) begin
    if (chk_a && Reset_n) begin
      check("a_valid", 32'(a_out_valid), 32'(qa.size() > 0));
      check("a_ready", 32'(a_in_ready), 32'(qa.size() < 2));
      check("b_valid", 32'(b_out_valid), 32'(qa.size() > 0));
      check("b_ready", 32'(b_in_ready), 32'(qa.size() < 2));
      if (qa.size() > 0) begin
        check("a_data", a_out_data, qa[0].da);
        check("a_err", 32'(a_err), 32'(0));
        check("b_data", b_out_data, qa[0].db);
        check("b_err", 32'(b_err), 32'(qa[0].eb));
      end
    end
    if (chk_c && Reset_n) begin
      check("c_valid", 32'(c_out_valid), 32'(qc.size() > 0));
      check("c_ready", 32'(c_in_ready), 32'(qc.size() < 2));
      if (qc.size() > 0) begin
        check("c_data", 32'(c_out_data), 32'(qc[0].d));
        check("c_err", 32'(c_err), 32'(qc[0].e));
      end
      if (c_prev_hold) check("c_stable", 32'(c_out_data), 32'(c_prev_data));
      c_prev_hold = c_out_valid && !c_out_ready && !c_flush;
      c_prev_data = c_out_data;
    end
  end

  typedef struct {
    logic [127:0] words;
    logic [1:0]   sel;
    logic [31:0]  exp_a;
    logic [31:0]  exp_b;
    logic         err_b;
  } vec_t;

  vec_t vecs[5];

  task automatic set_base_words();
    a_words[0] = 32'h11111111;
    a_words[1] = 32'h22222222;
    a_words[2] = 32'h33333333;
    a_words[3] = 32'h44444444;
  endtask

  initial begin
    vecs[0] = '{128'h44444444_33333333_22222222_11111111, 2'd2, 32'h33333333, 32'h33333333, 1'b0};
    vecs[1] = '{128'h44444444_33333333_22222222_11111111, 2'd3, 32'h44444444, 32'h33333333, 1'b1};
    vecs[2] = '{128'h44444444_33333333_22222222_11111111, 2'd0, 32'h11111111, 32'h11111111, 1'b0};
    vecs[3] = '{128'hA0A0A0A0_0BADF00D_CAFEF00D_12345678, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{128'hA0A0A0A0_0BADF00D_CAFEF00D_12345678, 2'd3, 32'hA0A0A0A0, 32'h0BADF00D, 1'b1};

    Reset_n = 1'b0;
    set_base_words();
    a_sel = '0; a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    for (int k = 0; k < 5; k++) c_words[k] = '0;
    c_sel = '0; c_in_valid = 0; c_out_ready = 0; c_flush = 0;

    repeat (2) tick();
    check("rst_a_valid", 32'(a_out_valid), 32'(0));
    check("rst_a_ready", 32'(a_in_ready), 32'(1));
    check("rst_a_data", a_out_data, 32'h0);
    check("rst_b_err", 32'(b_err), 32'(0));
    check("rst_c_valid", 32'(c_out_valid), 32'(0));
    check("rst_c_data", 32'(c_out_data), 32'(0));
    Reset_n = 1'b1;
    chk_a = 1;
    chk_c = 1;

    // Table vectors: single transfer, one-cycle latency, then drain.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) a_words[k] = vecs[i].words[k*32 +: 32];
      a_sel = vecs[i].sel;
      a_in_valid = 1; a_out_ready = 1;
      check("vec_pre_valid", 32'(a_out_valid), 32'(0));
      tick();
      a_in_valid = 0;
      check("vec_valid", 32'(a_out_valid), 32'(1));
      check("vec_a_data", a_out_data, vecs[i].exp_a);
      check("vec_b_data", b_out_data, vecs[i].exp_b);
      check("vec_b_err", 32'(b_err), 32'(vecs[i].err_b));
      tick();
      check("vec_drained", 32'(a_out_valid), 32'(0));
    end

    // Stall and skid: two words captured while downstream is blocked.
    set_base_words();
    a_out_ready = 0; a_in_valid = 1; a_sel = 2'd0;
    tick();
    a_sel = 2'd1;
    tick();
    a_in_valid = 0;
    check("skid_ready_low", 32'(a_in_ready), 32'(0));
    check("skid_head", a_out_data, 32'h11111111);
    tick();
    check("skid_hold", a_out_data, 32'h11111111);
    check("skid_hold_valid", 32'(a_out_valid), 32'(1));
    a_out_ready = 1;
    tick();
    check("skid_second", a_out_data, 32'h22222222);
    check("skid_ready_back", 32'(a_in_ready), 32'(1));
    tick();
    check("skid_empty", 32'(a_out_valid), 32'(0));

    // Flush while full, with a word offered in the flush cycle.
    a_out_ready = 0; a_in_valid = 1; a_sel = 2'd0;
    tick();
    a_sel = 2'd1;
    tick();
    a_flush = 1; a_sel = 2'd3;
    tick();
    a_flush = 0; a_in_valid = 0;
    check("flush2_valid", 32'(a_out_valid), 32'(0));
    check("flush2_ready", 32'(a_in_ready), 32'(1));
    a_out_ready = 1;
    repeat (3) begin
      tick();
      check("flush2_gone", 32'(a_out_valid), 32'(0));
    end

    // Flush in ONE while a new word is actually accepted.
    a_out_ready = 0; a_in_valid = 1; a_sel = 2'd0;
    tick();
    a_flush = 1; a_sel = 2'd3;
    tick();
    a_flush = 0; a_in_valid = 0;
    check("flush1_valid", 32'(a_out_valid), 32'(0));
    check("flush1_ready", 32'(a_in_ready), 32'(1));
    a_out_ready = 1;
    tick();
    check("flush1_gone", 32'(a_out_valid), 32'(0));

    // Asynchronous reset between edges while holding a word.
    a_out_ready = 0; a_in_valid = 1; a_sel = 2'd2;
    tick();
    a_in_valid = 0;
    check("pre_rst_valid", 32'(a_out_valid), 32'(1));
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(a_out_valid), 32'(0));
    check("async_rst_data", a_out_data, 32'h0);
    check("async_rst_ready", 32'(a_in_ready), 32'(1));
    @(negedge Clk);
    #1 Reset_n = 1'b1;

    // 16 random transfers after reset release.
    begin
      int start, cyc;
      start = acc_a;
      cyc = 0;
      while ((acc_a - start) < 16 && cyc < 400) begin
        for (int k = 0; k < 4; k++) a_words[k] = $urandom;
        a_sel = 2'($urandom_range(0, 3));
        a_in_valid = ($urandom_range(0, 3) != 0);
        a_out_ready = ($urandom_range(0, 2) != 0);
        tick();
        cyc++;
      end
      check("stream16_done", 32'((acc_a - start) >= 16), 32'(1));
      a_in_valid = 0; a_out_ready = 1;
      repeat (3) tick();
    end

    // Random soak on the 8-bit, 5-input instance.
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 5; k++) c_words[k] = 8'($urandom);
      c_sel = 3'($urandom_range(0, 7));
      c_in_valid = ($urandom_range(0, 3) != 0);
      c_out_ready = ($urandom_range(0, 2) != 0);
      c_flush = ($urandom_range(0, 49) == 0);
      tick();
    end
    c_in_valid = 0; c_flush = 0; c_out_ready = 1;
    repeat (3) tick();
    check("soak_drained", 32'(c_out_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
